// File: rtl/tl_fsm_timed.sv
// rtl/tl_fsm_timed.sv - two-road traffic-light controller with min/max green and fixed yellow timing
module tl_fsm_timed #(
   parameter int CNT_W         = 4,
   parameter int GREEN_MIN     = 3,
   parameter int GREEN_MAX     = 10,
   parameter int YELLOW_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             Ta,
   input  logic             Tb,
   output logic [1:0]       La,
   output logic [1:0]       Lb,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cnt,
   output logic             sw
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;

   localparam logic [1:0] LAMP_GREEN  = 2'b00;
   localparam logic [1:0] LAMP_YELLOW = 2'b01;
   localparam logic [1:0] LAMP_RED    = 2'b10;

   // Comparison points are "last cycle" indices, since cnt is 0 in the first cycle.
   localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             sw_q;
   logic             adv;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S0;
         cnt_q   <= '0;
         sw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sw_q    <= adv;
         if (adv)
            cnt_q <= '0;
         else if (cnt_q != CNT_SAT)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S0: if ((cnt_q >= GMIN_LAST && !Ta) || cnt_q == GMAX_LAST) state_d = S1;
         S1: if (cnt_q == YEL_LAST) state_d = S2;
         S2: if ((cnt_q >= GMIN_LAST && !Tb) || cnt_q == GMAX_LAST) state_d = S3;
         S3: if (cnt_q == YEL_LAST) state_d = S0;
         default: state_d = S0;
      endcase
      adv = (state_d != state_q);
   end

   // Moore lamp decode: depends on the state register only.
   always_comb begin
      La = LAMP_RED;
      Lb = LAMP_RED;
      case (state_q)
         S0: La = LAMP_GREEN;
         S1: La = LAMP_YELLOW;
         S2: Lb = LAMP_GREEN;
         S3: Lb = LAMP_YELLOW;
         default: begin
            La = LAMP_RED;
            Lb = LAMP_RED;
         end
      endcase
   end

   assign state = state_q;
   assign cnt   = cnt_q;
   assign sw    = sw_q;

endmodule

// File: tb/tb_tl_fsm_timed.sv
// tb/tb_tl_fsm_timed.sv - directed self-checking bench for tl_fsm_timed
module tb_tl_fsm_timed;

   logic       clk;
   logic       clk_en;
   logic       reset_n;
   logic       Ta, Tb;
   logic [1:0] La, Lb, state;
   logic [3:0] cnt;
   logic       sw;
   logic [1:0] f_La, f_Lb, f_state;
   logic [3:0] f_cnt;
   logic       f_sw;

   int total;
   int bad;

   // Default-parameter run, Ta=Tb=0: expected per cycle 0..10 (index = cycle).
   localparam logic [10:0][1:0] DEF_ST  = {2'd0, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
   localparam logic [10:0][3:0] DEF_CNT = {4'd0, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
   localparam logic [10:0]      DEF_SW  = 11'b10100101000;

   tl_fsm_timed dut (
      .clk(clk), .reset_n(reset_n), .Ta(Ta), .Tb(Tb),
      .La(La), .Lb(Lb), .state(state), .cnt(cnt), .sw(sw)
   );

   tl_fsm_timed #(.CNT_W(4), .GREEN_MIN(1), .GREEN_MAX(1), .YELLOW_CYCLES(1)) dut_fast (
      .clk(clk), .reset_n(reset_n), .Ta(Ta), .Tb(Tb),
      .La(f_La), .Lb(f_Lb), .state(f_state), .cnt(f_cnt), .sw(f_sw)
   );

   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   function automatic logic [1:0] lamp_a(input logic [1:0] st);
      case (st)
         2'd0:    lamp_a = 2'b00;
         2'd1:    lamp_a = 2'b01;
         default: lamp_a = 2'b10;
      endcase
   endfunction

   function automatic logic [1:0] lamp_b(input logic [1:0] st);
      case (st)
         2'd2:    lamp_b = 2'b00;
         2'd3:    lamp_b = 2'b01;
         default: lamp_b = 2'b10;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", state); end
      total++; if (cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
      total++; if (sw !== 1'b0) begin bad++; $display("FAIL reset_sw got=%b exp=0", sw); end
      total++; if (La !== 2'b00) begin bad++; $display("FAIL reset_La got=%b exp=00", La); end
      total++; if (Lb !== 2'b10) begin bad++; $display("FAIL reset_Lb got=%b exp=10", Lb); end
      total++; if (f_state !== 2'b00) begin bad++; $display("FAIL reset_fast_state got=%b exp=00", f_state); end
      clk_en = 1'b1;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_default_cycle();
      Ta = 1'b0;
      Tb = 1'b0;
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) tick();
         total++; if (state !== DEF_ST[c]) begin bad++; $display("FAIL default_state c=%0d got=%0d exp=%0d", c, state, DEF_ST[c]); end
         total++; if (cnt !== DEF_CNT[c]) begin bad++; $display("FAIL default_cnt c=%0d got=%0d exp=%0d", c, cnt, DEF_CNT[c]); end
         total++; if (sw !== DEF_SW[c]) begin bad++; $display("FAIL default_sw c=%0d got=%b exp=%b", c, sw, DEF_SW[c]); end
         total++; if (La !== lamp_a(DEF_ST[c])) begin bad++; $display("FAIL default_La c=%0d got=%b exp=%b", c, La, lamp_a(DEF_ST[c])); end
         total++; if (Lb !== lamp_b(DEF_ST[c])) begin bad++; $display("FAIL default_Lb c=%0d got=%b exp=%b", c, Lb, lamp_b(DEF_ST[c])); end
      end
   endtask

   task automatic test_max_green();
      Ta = 1'b1;
      Tb = 1'b0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) tick();
         total++; if (state !== 2'd0) begin bad++; $display("FAIL maxg_state c=%0d got=%0d exp=0", c, state); end
         total++; if (cnt !== 4'(c)) begin bad++; $display("FAIL maxg_cnt c=%0d got=%0d exp=%0d", c, cnt, c); end
      end
      tick();
      total++; if (state !== 2'd1) begin bad++; $display("FAIL maxg_exit_state got=%0d exp=1", state); end
      total++; if (La !== 2'b01) begin bad++; $display("FAIL maxg_exit_La got=%b exp=01", La); end
      total++; if (Lb !== 2'b10) begin bad++; $display("FAIL maxg_exit_Lb got=%b exp=10", Lb); end
      total++; if (sw !== 1'b1) begin bad++; $display("FAIL maxg_exit_sw got=%b exp=1", sw); end
      Ta = 1'b0;
   endtask

   task automatic test_sensor_drop();
      // Ta high for cycles 0..4, low from cycle 5; Tb high must not matter in S0.
      Ta = 1'b1;
      Tb = 1'b1;
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) tick();
         Ta = (c < 5);
         if (c == 5) begin
            total++; if (state !== 2'd0 || cnt !== 4'd5) begin bad++; $display("FAIL drop5_pre got=%0d/%0d exp=0/5", state, cnt); end
         end
         if (c == 6) begin
            total++; if (state !== 2'd1 || sw !== 1'b1) begin bad++; $display("FAIL drop5_s1 got=%0d/%b exp=1/1", state, sw); end
         end
      end
      // Ta drops at cnt=1: min green still holds S0 through cnt=2.
      Ta = 1'b1;
      Tb = 1'b0;
      do_reset();
      tick();
      Ta = 1'b0;
      total++; if (state !== 2'd0 || cnt !== 4'd1) begin bad++; $display("FAIL drop1_c1 got=%0d/%0d exp=0/1", state, cnt); end
      tick();
      total++; if (state !== 2'd0 || cnt !== 4'd2) begin bad++; $display("FAIL drop1_c2 got=%0d/%0d exp=0/2", state, cnt); end
      tick();
      total++; if (state !== 2'd1 || cnt !== 4'd0) begin bad++; $display("FAIL drop1_c3 got=%0d/%0d exp=1/0", state, cnt); end
   endtask

   task automatic test_reset_mid();
      Ta = 1'b0;
      Tb = 1'b0;
      do_reset();
      for (int c = 1; c <= 9; c++) tick();
      total++; if (state !== 2'd3 || cnt !== 4'd1) begin bad++; $display("FAIL mid_pre got=%0d/%0d exp=3/1", state, cnt); end
      #2 reset_n = 1'b0;
      #1;
      total++; if (state !== 2'd0 || cnt !== 4'd0 || sw !== 1'b0) begin bad++; $display("FAIL mid_async got=%0d/%0d/%b exp=0/0/0", state, cnt, sw); end
      total++; if (La !== 2'b00 || Lb !== 2'b10) begin bad++; $display("FAIL mid_lamps got=%b/%b exp=00/10", La, Lb); end
      tick();
      total++; if (state !== 2'd0 || sw !== 1'b0) begin bad++; $display("FAIL mid_held got=%0d/%b exp=0/0", state, sw); end
      reset_n = 1'b1;
      tick();
      tick();
      total++; if (state !== 2'd0 || cnt !== 4'd2) begin bad++; $display("FAIL mid_c2 got=%0d/%0d exp=0/2", state, cnt); end
      tick();
      total++; if (state !== 2'd1 || sw !== 1'b1) begin bad++; $display("FAIL mid_c3 got=%0d/%b exp=1/1", state, sw); end
   endtask

   task automatic test_back_to_back();
      Ta = 1'b1;
      Tb = 1'b1;
      do_reset();
      for (int c = 0; c <= 4; c++) begin
         if (c > 0) tick();
         total++; if (f_state !== 2'(c % 4)) begin bad++; $display("FAIL fast_state c=%0d got=%0d exp=%0d", c, f_state, c % 4); end
         total++; if (f_sw !== (c > 0)) begin bad++; $display("FAIL fast_sw c=%0d got=%b exp=%b", c, f_sw, (c > 0)); end
         total++; if (f_cnt !== 4'd0) begin bad++; $display("FAIL fast_cnt c=%0d got=%0d exp=0", c, f_cnt); end
         total++; if (f_La !== lamp_a(2'(c % 4)) || f_Lb !== lamp_b(2'(c % 4))) begin bad++; $display("FAIL fast_lamps c=%0d got=%b/%b", c, f_La, f_Lb); end
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      clk_en  = 1'b0;
      reset_n = 1'b1;
      Ta      = 1'b0;
      Tb      = 1'b0;
      test_reset();
      test_default_cycle();
      test_max_green();
      test_sensor_drop();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
